// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: N-channel LED sequencer.
// A start level in IDLE launches one sequence of N_STEPS patterns, each held
// PERIOD_CYCLES clocks, in ALT, BLINK or CHASE mode. The sequence then parks
// in DONE until start is released. abort returns to IDLE from RUN or DONE.
//
// Build option: define START_SYNC_EN to pass start and abort through a
// 2-flop synchronizer, which adds 2 cycles of latency. Leave it undefined
// when both inputs are already synchronous to clk.
//
// Handshake: none. start and abort are levels. All outputs are registered
// and change on the same edge as the FSM state.
module led_seq_ctrl #(
  parameter int                N_LEDS        = 2,
  parameter int                PERIOD_CYCLES = 25_000_000,
  parameter int                N_STEPS       = 10,
  parameter logic [N_LEDS-1:0] IDLE_PAT      = '1,
  parameter logic [N_LEDS-1:0] DONE_PAT      = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               abort,
  input  logic [1:0]                         mode,
  output logic [N_LEDS-1:0]                  leds,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(N_STEPS+1)-1:0]       step
);

  localparam int CNT_W  = $clog2(PERIOD_CYCLES);
  localparam int STEP_W = $clog2(N_STEPS + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(N_STEPS - 1);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

  localparam logic [1:0] MODE_BLINK = 2'd1;
  localparam logic [1:0] MODE_CHASE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [N_LEDS-1:0]   leds_q, leds_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          mode_q, mode_d;

  logic                start_s;
  logic                abort_s;

`ifdef START_SYNC_EN
  logic [1:0] start_sync_q, start_sync_d;
  logic [1:0] abort_sync_q, abort_sync_d;

  // Shift the raw button levels through two flops each.
  always_comb begin
    start_sync_d = {start_sync_q[0], start};
    abort_sync_d = {abort_sync_q[0], abort};
  end

  // Synchronizer flops, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_sync_q <= 2'b00;
      abort_sync_q <= 2'b00;
    end else begin
      start_sync_q <= start_sync_d;
      abort_sync_q <= abort_sync_d;
    end
  end

  assign start_s = start_sync_q[1];
  assign abort_s = abort_sync_q[1];
`else
  assign start_s = start;
  assign abort_s = abort;
`endif

  // First pattern shown when a sequence begins; reserved mode 3 acts as ALT.
  function automatic logic [N_LEDS-1:0] init_pat(input logic [1:0] m);
    logic [N_LEDS-1:0] r;
    r = '0;
    if (m == MODE_BLINK) begin
      r = '1;
    end else if (m == MODE_CHASE) begin
      r[0] = 1'b1;
    end else begin
      for (int i = 0; i < N_LEDS; i++) begin
        r[i] = (i % 2 == 0);
      end
    end
    return r;
  endfunction

  // Next pattern: CHASE rotates left with wrap, other modes invert.
  function automatic logic [N_LEDS-1:0] next_pat(input logic [1:0] m,
                                                 input logic [N_LEDS-1:0] p);
    logic [N_LEDS-1:0] r;
    r = ~p;
    if (m == MODE_CHASE) begin
      for (int i = 0; i < N_LEDS; i++) begin
        r[i] = p[(i + N_LEDS - 1) % N_LEDS];
      end
    end
    return r;
  endfunction

  // Next-state and registered-output logic; abort beats start and wrap.
  always_comb begin
    state_d = state_q;
    leds_d  = leds_q;
    busy_d  = busy_q;
    done_d  = done_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;

    case (state_q)
      S_IDLE: begin
        leds_d = IDLE_PAT;
        busy_d = 1'b0;
        done_d = 1'b0;
        step_d = '0;
        cnt_d  = '0;
        if (start_s && !abort_s) begin
          state_d = S_RUN;
          mode_d  = mode;
          leds_d  = init_pat(mode);
          busy_d  = 1'b1;
        end
      end

      S_RUN: begin
        if (abort_s) begin
          state_d = S_IDLE;
          leds_d  = IDLE_PAT;
          busy_d  = 1'b0;
          step_d  = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (step_q == STEP_LAST) begin
            state_d = S_DONE;
            leds_d  = DONE_PAT;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            step_d  = '0;
          end else begin
            step_d = step_q + STEP_ONE;
            leds_d = next_pat(mode_q, leds_q);
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_DONE: begin
        if (abort_s || !start_s) begin
          state_d = S_IDLE;
          leds_d  = IDLE_PAT;
          done_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        leds_d  = IDLE_PAT;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        step_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      leds_q  <= IDLE_PAT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      step_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      leds_q  <= leds_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign leds = leds_q;
  assign busy = busy_q;
  assign done = done_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Testbench for led_seq_ctrl: three instances driven with the same stimulus
// (4 LEDs/period 4/3 steps; 1 LED/period 2/3 steps; 2 LEDs/period 2/1 step).
// A timeline model predicts every registered output from elapsed time since
// start; the prediction for each edge is queued and checked after that edge.
module tb_led_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [1:0] mode;

  logic [3:0] leds0;
  logic       busy0, done0;
  logic [1:0] step0;
  logic [0:0] leds1;
  logic       busy1, done1;
  logic [1:0] step1;
  logic [1:0] leds2;
  logic       busy2, done2;
  logic [0:0] step2;

  led_seq_ctrl #(.N_LEDS(4), .PERIOD_CYCLES(4), .N_STEPS(3)) dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .leds(leds0), .busy(busy0), .done(done0), .step(step0)
  );

  led_seq_ctrl #(.N_LEDS(1), .PERIOD_CYCLES(2), .N_STEPS(3)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .leds(leds1), .busy(busy1), .done(done1), .step(step1)
  );

  led_seq_ctrl #(.N_LEDS(2), .PERIOD_CYCLES(2), .N_STEPS(1)) dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .leds(leds2), .busy(busy2), .done(done2), .step(step2)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  localparam int W = 24;  // 3 instances x {leds[3:0], busy, done, step[1:0]}

  int nl_p[3]  = '{4, 1, 2};
  int per_p[3] = '{4, 2, 2};
  int ns_p[3]  = '{3, 3, 1};

  bit running[3];
  bit finished[3];
  int elapsed[3];
  int mode_l[3];
  bit h1_s, h2_s, h1_a, h2_a;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Pattern number k of a sequence, straight from the mode rules.
  function automatic logic [3:0] pat(input int m, input int k, input int nl);
    logic [3:0] mask;
    logic [3:0] alt;
    mask = 4'((1 << nl) - 1);
    alt  = 4'b0101 & mask;
    if (m == 1) return (k % 2 == 0) ? mask : 4'b0000;
    if (m == 2) return 4'(1 << (k % nl));
    return (k % 2 == 0) ? alt : (~alt & mask);
  endfunction

  function automatic logic [7:0] exp_word(input int i);
    logic [3:0] mask;
    int k;
    mask = 4'((1 << nl_p[i]) - 1);
    if (running[i]) begin
      k = elapsed[i] / per_p[i];
      return {pat(mode_l[i], k, nl_p[i]), 1'b1, 1'b0, 2'(k)};
    end
    if (finished[i]) return {4'b0000, 1'b0, 1'b1, 2'b00};
    return {mask, 1'b0, 1'b0, 2'b00};
  endfunction

  task automatic model_edge(input bit s, input bit a, input int m, input bit r);
    bit es, ea;
    if (r) begin
      for (int i = 0; i < 3; i++) begin
        running[i] = 0; finished[i] = 0; elapsed[i] = 0;
      end
      h1_s = 0; h2_s = 0; h1_a = 0; h2_a = 0;
      return;
    end
`ifdef START_SYNC_EN
    es = h2_s; ea = h2_a;
    h2_s = h1_s; h1_s = s;
    h2_a = h1_a; h1_a = a;
`else
    es = s; ea = a;
`endif
    for (int i = 0; i < 3; i++) begin
      if (running[i]) begin
        if (ea) begin
          running[i] = 0;
        end else begin
          elapsed[i]++;
          if (elapsed[i] == ns_p[i] * per_p[i]) begin
            running[i] = 0; finished[i] = 1;
          end
        end
      end else if (finished[i]) begin
        if (ea || !es) finished[i] = 0;
      end else if (es && !ea) begin
        running[i] = 1; elapsed[i] = 0; mode_l[i] = m;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock of stimulus: inputs change at negedge, prediction for the next
  // posedge is queued. A rising rst here lands mid-cycle, so the reset
  // values are checked right away, before any clock edge.
  task automatic cyc(input bit s, input bit a, input int m, input bit r);
    logic [7:0] got;
    @(negedge clk);
    start = s; abort = a; mode = 2'(m);
    if (r && !rst) begin
      rst = 1'b1;
      #1;
      got = {leds0, busy0, done0, step0};
      checks++;
      if (got !== 8'hF0) begin
        errors++;
        $display("FAIL async_rst got %h exp %h", got, 8'hF0);
      end
    end else begin
      rst = r;
    end
    model_edge(s, a, m, r);
    exp_q.push_back({exp_word(2), exp_word(1), exp_word(0)});
  endtask

  task automatic hold(input int n, input bit s, input bit a, input int m);
    for (int i = 0; i < n; i++) cyc(s, a, m, 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] act;
    #1;
    cycle++;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {2'b00, leds2, busy2, done2, 1'b0, step2,
             3'b000, leds1, busy1, done1, step1,
             leds0, busy0, done0, step0};
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act[i*8 +: 8] !== e[i*8 +: 8]) begin
          errors++;
          $display("FAIL inst%0d cyc %0d {leds,busy,done,step} got %h exp %h",
                   i, cycle, act[i*8 +: 8], e[i*8 +: 8]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    hold(2, 0, 0, 0);

    // ALT single-cycle start, run to DONE and back
    cyc(1, 0, 0, 0);
    hold(18, 0, 0, 0);

    // CHASE with start held through DONE, then release
    hold(20, 1, 0, 2);
    hold(3, 0, 0, 2);

    // reserved mode 3, then mode flipped to BLINK mid-run
    cyc(1, 0, 3, 0);
    hold(2, 0, 0, 3);
    hold(16, 0, 0, 1);

    // BLINK run
    cyc(1, 0, 1, 0);
    hold(18, 0, 0, 1);

    // abort six cycles into a run
    cyc(1, 0, 0, 0);
    hold(5, 0, 0, 0);
    cyc(0, 1, 0, 0);
    hold(4, 0, 0, 0);

    // start and abort together in IDLE
    hold(4, 1, 1, 0);
    hold(2, 0, 0, 0);

    // asynchronous reset in the middle of a run
    cyc(1, 0, 2, 0);
    hold(6, 0, 0, 2);
    cyc(0, 0, 0, 1);
    hold(3, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 4,
          $urandom_range(0, 3), $urandom_range(0, 199) == 0);
    end
    hold(20, 0, 0, 0);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain queue_left %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
Parametrised LED sequencer for the board status LEDs. It generalises the fixed two-LED, 1 s, 10-toggle blink into N channels with configurable step period, step count, pattern mode and idle/done patterns. A start input (button level) triggers one sequence, and an abort input cancels it. The block sits between the button input and the LED pins in board top levels.

Parameters:
N_LEDS, 2, number of LED channels (>=1)
PERIOD_CYCLES, 25_000_000, clk cycles each pattern is held (>=2; 1 s at 25 MHz)
N_STEPS, 10, patterns shown per sequence, including the initial one (>=1)
IDLE_PAT, all ones (N_LEDS bits), LED value in IDLE and after reset
DONE_PAT, all zeros (N_LEDS bits), LED value in DONE

Ports:
clk  in  1  system clock, 25 MHz
rst  in  1  asynchronous, active-high reset
start  in  1  sequence request, level (button)
abort  in  1  cancel the running sequence, level
mode  in  2  pattern mode: 0 ALT, 1 BLINK, 2 CHASE, 3 reserved (treated as ALT)
leds  out  N_LEDS  LED drive, registered
busy  out  1  high in RUN
done  out  1  high in DONE
step  out  $clog2(N_STEPS+1)  index of the current pattern in RUN, 0 otherwise

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. All state is in clk-domain flops.
- Reset values: state=IDLE, leds=IDLE_PAT, busy=0, done=0, step=0, period counter=0. Reset takes effect immediately, including mid-sequence.
- Internal widths: period counter is $clog2(PERIOD_CYCLES) bits; step counter is $clog2(N_STEPS+1) bits.
- FSM states: IDLE, RUN, DONE. All outputs are registered and update in the same cycle as the state change.
- IDLE:
  - leds=IDLE_PAT.
  - If start=1 and abort=0 at a clk edge: latch mode, clear counters and go to RUN.
  - Initial leds on entry to RUN:
    - ALT: even bits 1, odd bits 0 (N_LEDS=4 gives 4'b0101).
    - BLINK: all ones.
    - CHASE: only bit0 set.
  - If start and abort are both high, abort wins and the block stays in IDLE.
- RUN:
  - busy=1. The period counter increments every cycle and wraps to 0 at PERIOD_CYCLES-1.
  - At each wrap, if step<N_STEPS-1: step+1 and advance the pattern.
    - ALT and BLINK: invert all bits.
    - CHASE: rotate left by 1, MSB wraps to bit0. N_LEDS=1 gives a constant pattern.
  - At the wrap with step==N_STEPS-1: leds=DONE_PAT, step=0, go to DONE.
  - Each pattern is held exactly PERIOD_CYCLES cycles. Total RUN time is N_STEPS*PERIOD_CYCLES cycles.
  - The mode input and start are ignored during RUN; the latched mode is used.
  - abort=1: go to IDLE on the next edge (leds=IDLE_PAT, busy=0, counters cleared). abort takes priority over a coincident wrap.
- DONE:
  - leds=DONE_PAT, done=1.
  - Go to IDLE when start==0. A held start does not retrigger (the button must be released).
  - abort=1 also returns the block to IDLE.
- Illegal state encoding: go to IDLE.

Optional Feature:
START_SYNC_EN:
- Defined: start and abort each pass through a 2-flop synchronizer (flops reset to 0) before the FSM. This adds exactly 2 cycles of response latency to both inputs. For use with raw button pins.
- Undefined: start and abort feed the FSM directly, with zero added latency. The caller must supply synchronous inputs.

Test Plan:
(All tests use N_LEDS=4, PERIOD_CYCLES=4, N_STEPS=3, macro undefined unless stated.)
1. Reset and ALT sequence:
   - rst pulse -> leds=4'b1111, busy=0, done=0, step=0.
   - mode=0, start high 1 cycle at edge E -> after E: leds=0101, busy=1, step=0.
   - E+4: leds=1010, step=1. E+8: 0101, step=2. E+12: leds=0000, done=1, busy=0.
2. CHASE, start held:
   - mode=2 -> 0001 at E, 0010 at E+4, 0100 at E+8, 0000 and done at E+12.
   - start still high -> remains in DONE. Drop start -> next edge leds=1111, done=0.
3. Mode handling:
   - mode=3 -> identical to ALT.
   - mode switched to 1 at E+2 -> sequence still ALT.
   - Separate run with mode=1 -> 1111, 0000, 1111, then DONE_PAT.
4. Abort and reset:
   - abort at E+6 -> next edge leds=1111, busy=0, step=0.
   - start and abort together in IDLE -> stays IDLE.
   - rst asserted asynchronously at E+5 plus half a cycle -> leds=1111 immediately, without waiting for clk.
5. Macro defined: same stimulus as test 1 -> every transition is delayed by exactly 2 cycles (leds=0101 at E+2, DONE at E+14).
6. Boundary: N_STEPS=1, PERIOD_CYCLES=2 -> initial pattern held 2 cycles, then DONE. N_LEDS=1 CHASE -> leds stays 1 through all steps.
